conv_encoder: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder (generators 7/5 octal) that feeds the Viterbi decoder stage. It accepts one PCM byte per frame over a valid/ready handshake and serialises it MSB-first into one 2-bit code symbol per clock. Each frame is padded with a zero tail and an idle gap, so the downstream decoder always starts from state 00, syncs on the first symbol, and completes traceback before the next frame arrives.

---
 rtl/conv_pkg.sv | 9 +
 rtl/conv_enc_core.sv | 14 +
 rtl/conv_encoder.sv | 98 +++++++++
 tb/tb_conv_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, generator taps and FSM state type for the convolutional encoder
package conv_pkg;
    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G0 = 3'b101;
    localparam int BYTE_W = 8;
    localparam int FRAME_LEN_DEF = 16;
    localparam int TAIL_LEN_DEF = 2;
    typedef enum logic [1:0] {IDLE, DATA, TAIL, GAP} state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: one combinational step of the 7/5 K=3 encoder, taps ordered {u, s1, s0}
module conv_enc_core
    import conv_pkg::*;
(
    input  logic       u,
    input  logic [1:0] s,
    output logic [1:0] sym,
    output logic [1:0] s_next
);
    logic [2:0] taps;
    assign taps = {u, s};
    assign sym = {^(taps & G1), ^(taps & G0)};
    assign s_next = {u, s[1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 encoder, one byte per frame, MSB first, zero tail then 00 gap
module conv_encoder
    import conv_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TAIL_LEN = TAIL_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [1:0]        conv_code,
    output logic              busy,
    output logic              sync_err
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int IW = $clog2(BYTE_W);
    localparam logic [CW-1:0] LAST_DATA = CW'(BYTE_W - 1);
    localparam logic [CW-1:0] LAST_TAIL = CW'(BYTE_W + TAIL_LEN - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [1:0]        s, s_n, code_n, sym, s_next;
    logic [BYTE_W-1:0] sreg, sreg_n;
    logic              err_n, u, accept;

    assign din_ready = (state == IDLE) || (cnt == LAST_CNT);
    assign busy = state != IDLE;
    assign accept = din_valid && din_ready;

    conv_enc_core u_core (
        .u(u),
        .s(s),
        .sym(sym),
        .s_next(s_next)
    );

    // next-state logic: an accept emits the first symbol from s=00 directly, otherwise step the frame
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        s_n = s;
        sreg_n = sreg;
        code_n = 2'b00;
        err_n = 1'b0;
        u = 1'b0;
        if (accept) begin
            state_n = DATA;
            cnt_n = CW'(1);
            sreg_n = din;
            code_n = {din[BYTE_W-1], din[BYTE_W-1]};
            s_n = {din[BYTE_W-1], 1'b0};
            err_n = ~din[BYTE_W-1];
        end else begin
            case (state)
                DATA: begin
                    u = sreg[IW'(LAST_DATA - cnt)];
                    code_n = sym;
                    s_n = s_next;
                    cnt_n = cnt + CW'(1);
                    state_n = (cnt == LAST_DATA) ? TAIL : DATA;
                end
                TAIL: begin
                    code_n = sym;
                    s_n = s_next;
                    cnt_n = cnt + CW'(1);
                    state_n = (cnt == LAST_TAIL) ? GAP : TAIL;
                end
                GAP: begin
                    cnt_n = (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
                    state_n = (cnt == LAST_CNT) ? IDLE : GAP;
                end
                default: cnt_n = '0;
            endcase
        end
    end

    // state and registered outputs; reset drops any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            s <= 2'b00;
            sreg <= '0;
            conv_code <= 2'b00;
            sync_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            s <= s_n;
            sreg <= sreg_n;
            conv_code <= code_n;
            sync_err <= err_n;
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: random and directed stimulus checked against a convolution-sum frame model
module tb_conv_encoder;
    localparam int FL = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] conv_code;
    logic       busy;
    logic       sync_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    int pos = 0;
    bit acc_pending = 1'b0;
    logic [1:0] q[$];
    logic [1:0] e_code = 2'b00;
    logic e_busy = 1'b0;
    logic e_err = 1'b0;
    logic e_ready;
    logic [19:0] lit_b4;
    logic [19:0] lit_ff;
    int t0, t1;

    conv_encoder dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .conv_code(conv_code),
        .busy(busy),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic bit_at(input logic [7:0] d, input int k);
        return (k >= 0 && k < 8) ? d[3'(7 - k)] : 1'b0;
    endfunction

    // symbol k of a frame is the convolution of the MSB-first bit stream (zeros before and after)
    function automatic logic [1:0] sym_at(input logic [7:0] d, input int k);
        logic b0, b1, b2;
        b0 = bit_at(d, k);
        b1 = bit_at(d, k - 1);
        b2 = bit_at(d, k - 2);
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit keep, output int at);
        din = d;
        din_valid = 1'b1;
        at = -1;
        for (int i = 0; i < 100 && at < 0; i++) begin
            @(posedge clk);
            #1;
            if (acc_pending) at = last_acc;
        end
        if (at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h never accepted", d);
        end
        if (!keep) din_valid = 1'b0;
    endtask

    // compare process: check outputs, then predict what the next rising edge produces
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                pos = 0;
                q.delete();
                e_code = 2'b00;
                e_busy = 1'b0;
                e_err = 1'b0;
            end
            e_ready = (pos == 0) || (pos == FL - 1);
            chk("conv_code", 32'(conv_code), 32'(e_code));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("sync_err", 32'(sync_err), 32'(e_err));
            chk("din_ready", 32'(din_ready), 32'(e_ready));
            acc_pending = reset && din_valid && e_ready;
            if (acc_pending) begin
                last_acc = cyc;
                q.delete();
                for (int k = 0; k < FL; k++) q.push_back(sym_at(din, k));
                pos = 1;
                e_err = ~din[7];
            end else begin
                e_err = 1'b0;
                if (pos != 0) pos = (pos == FL - 1) ? 0 : pos + 1;
            end
            e_code = (q.size() != 0) ? q.pop_front() : 2'b00;
            e_busy = pos != 0;
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        lit_b4 = 20'b11_10_00_01_01_00_10_11_00_00;
        lit_ff = 20'b11_01_10_10_10_10_10_10_01_11;
        for (int k = 0; k < 10; k++) begin
            chk("model_b4", 32'(sym_at(8'hB4, k)), 32'(lit_b4[19 - 2 * k -: 2]));
            chk("model_ff", 32'(sym_at(8'hFF, k)), 32'(lit_ff[19 - 2 * k -: 2]));
        end
        chk("model_35_first", 32'(sym_at(8'h35, 0)), 32'(2'b00));
        for (int k = 10; k < FL; k++) chk("model_gap", 32'(sym_at(8'hFF, k)), 32'(2'b00));
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        idle(3);

        send(8'hB4, 1'b0, t0);
        idle(20);
        send(8'hFF, 1'b0, t0);
        idle(20);

        send(8'h35, 1'b0, t0);
        @(negedge clk);
        chk("msb0_err_pulse", 32'(sync_err), 32'(1'b1));
        chk("msb0_first_sym", 32'(conv_code), 32'(2'b00));
        @(negedge clk);
        chk("msb0_err_clear", 32'(sync_err), 32'(1'b0));
        idle(20);

        send(8'hB4, 1'b1, t0);
        send(8'h81, 1'b0, t1);
        chk("b2b_spacing", 32'(t1 - t0), 32'(FL - 1));
        idle(20);

        send(8'hB4, 1'b0, t0);
        idle(4);
        chk("bp_ready_low", 32'(din_ready), 32'(1'b0));
        send(8'h5A, 1'b0, t1);
        chk("bp_spacing", 32'(t1 - t0), 32'(FL - 1));
        idle(20);

        send(8'hB4, 1'b0, t0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_code", 32'(conv_code), 32'(2'b00));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_err", 32'(sync_err), 32'(1'b0));
        chk("rst_ready", 32'(din_ready), 32'(1'b1));
        @(negedge clk);
        #2 reset = 1'b1;
        idle(2);
        send(8'hB4, 1'b0, t0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_then_b4", 32'(conv_code), 32'(lit_b4[19 - 2 * k -: 2]));
        end
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!din_valid || acc_pending) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = 8'($urandom);
            end
        end
        din_valid = 1'b0;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
